// File: rtl/taus_urng_pkg.sv
// Shared constants, state types and the pure step/sanitise functions for the
// multi-channel taus88 uniform generator.
package taus_urng_pkg;

  localparam logic [31:0] DEF_S0 = 32'hDEAD_BEEF;
  localparam logic [31:0] DEF_S1 = 32'hCAFE_F00D;
  localparam logic [31:0] DEF_S2 = 32'h0BAD_F00D;

  localparam logic [31:0] MASK0 = 32'hFFFF_FFFE;
  localparam logic [31:0] MASK1 = 32'hFFFF_FFF8;
  localparam logic [31:0] MASK2 = 32'hFFFF_FFF0;

  localparam int SH0_A = 13, SH0_B = 19, SH0_C = 12;
  localparam int SH1_A = 2,  SH1_B = 25, SH1_C = 4;
  localparam int SH2_A = 3,  SH2_B = 11, SH2_C = 17;

  // Each component degenerates if its masked-off low bits are all it has.
  localparam logic [31:0] MIN_S0 = 32'd2;
  localparam logic [31:0] MIN_S1 = 32'd8;
  localparam logic [31:0] MIN_S2 = 32'd16;

  typedef enum logic [1:0] {IDLE, WARM, RUN} taus_fsm_e;

  typedef struct packed {
    logic [31:0] s0;
    logic [31:0] s1;
    logic [31:0] s2;
  } taus_state_t;

  function automatic taus_state_t taus_step(input logic [31:0] s0,
                                            input logic [31:0] s1,
                                            input logic [31:0] s2);
    taus_state_t n;
    n.s0 = ((s0 & MASK0) << SH0_C) ^ (((s0 << SH0_A) ^ s0) >> SH0_B);
    n.s1 = ((s1 & MASK1) << SH1_C) ^ (((s1 << SH1_A) ^ s1) >> SH1_B);
    n.s2 = ((s2 & MASK2) << SH2_C) ^ (((s2 << SH2_A) ^ s2) >> SH2_B);
    return n;
  endfunction

  function automatic taus_state_t taus_sanitise(input logic [31:0] s0,
                                                input logic [31:0] s1,
                                                input logic [31:0] s2);
    taus_state_t n;
    n.s0 = (s0 < MIN_S0) ? (s0 | MIN_S0) : s0;
    n.s1 = (s1 < MIN_S1) ? (s1 | MIN_S1) : s1;
    n.s2 = (s2 < MIN_S2) ? (s2 | MIN_S2) : s2;
    return n;
  endfunction

endpackage

// File: rtl/taus_urng_mc_lane.sv
// One taus88 channel: three state registers with seed load and step enable,
// exposing the combinational 32-bit word of the current state.
module taus_lane
  import taus_urng_pkg::*;
#(
  parameter int unsigned LANE_IDX = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed_s0,
  input  logic [31:0] seed_s1,
  input  logic [31:0] seed_s2,
  output logic [31:0] word
);

  taus_state_t st;

  // NOTE: clocked state uses non-blocking (<=) so every lane samples its
  // pre-edge value; these are plain registers, so a full async reset is fine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= '{s0: DEF_S0 + 32'(LANE_IDX),
              s1: DEF_S1 + 32'(LANE_IDX),
              s2: DEF_S2 + 32'(LANE_IDX)};
    end else if (load) begin
      st <= taus_sanitise(seed_s0, seed_s1, seed_s2);
    end else if (step) begin
      st <= taus_step(st.s0, st.s1, st.s2);
    end
  end

  assign word = st.s0 ^ st.s1 ^ st.s2;

endmodule

// File: rtl/taus_urng_mc.sv
// Multi-channel taus88 URNG: NUM_CH lockstep lanes, IDLE/WARM/RUN control with
// a warm-up discard counter and a valid/ready output handshake.
module taus_urng_mc
  import taus_urng_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int OUT_W  = 32,
  parameter int WARMUP = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [CH_W-1:0]         seed_ch,
  input  logic [31:0]             seed_s0,
  input  logic [31:0]             seed_s1,
  input  logic [31:0]             seed_s2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic                    busy
);

  taus_fsm_e   state;
  logic [15:0] warm_cnt;
  logic        seed_wr;
  logic        step_en;

  assign seed_wr = seed_valid & seed_ready;
  // One shared enable keeps all lanes in lockstep; stop suppresses the step.
  assign step_en = !stop && ((state == WARM) || (state == RUN && out_ready));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [31:0] lane_word;

    // Out-of-range channel indices match no lane, so the write is dropped.
    taus_lane #(.LANE_IDX(k)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (seed_wr && (seed_ch == CH_W'(k))),
      .step    (step_en),
      .seed_s0 (seed_s0),
      .seed_s1 (seed_s1),
      .seed_s2 (seed_s2),
      .word    (lane_word)
    );

    assign out_data[k*OUT_W +: OUT_W] = OUT_W'(lane_word >> (32 - OUT_W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      warm_cnt   <= '0;
      seed_ready <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else if (stop) begin
      state      <= IDLE;
      warm_cnt   <= '0;
      seed_ready <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            seed_ready <= 1'b0;
            busy       <= 1'b1;
            if (WARMUP == 0) begin
              state     <= RUN;
              out_valid <= 1'b1;
            end else begin
              state    <= WARM;
              warm_cnt <= 16'(WARMUP);
            end
          end
        end
        WARM: begin
          if (warm_cnt == 16'd1) begin
            state     <= RUN;
            out_valid <= 1'b1;
            warm_cnt  <= '0;
          end else begin
            warm_cnt <= warm_cnt - 16'd1;
          end
        end
        RUN: ;
        default: begin
          state      <= IDLE;
          warm_cnt   <= '0;
          seed_ready <= 1'b1;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_taus_urng_mc.sv
// Directed/random bench for taus_urng_mc: a WARMUP=0 32-bit instance and a
// WARMUP=16 16-bit instance share stimulus, checked against a taus88 model.
module tb_taus_urng_mc;

  localparam int N0 = 3, W0 = 32, WU0 = 0;
  localparam int N1 = 4, W1 = 16, WU1 = 16;

  logic clk = 1'b0;
  logic rst, start, stop, seed_valid, out_ready;
  logic [1:0]  seed_ch;
  logic [31:0] seed_s0, seed_s1, seed_s2;

  logic d0_seed_ready, d0_out_valid, d0_busy;
  logic d1_seed_ready, d1_out_valid, d1_busy;
  logic [N0*W0-1:0] d0_out_data;
  logic [N1*W1-1:0] d1_out_data;

  int n_assert = 0;
  int n_fail   = 0;
  int active_n = N0;
  logic [31:0] ms [16][3];

  always #5 clk = ~clk;

  taus_urng_mc #(.NUM_CH(N0), .OUT_W(W0), .WARMUP(WU0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed_valid(seed_valid), .seed_ready(d0_seed_ready), .seed_ch(seed_ch),
    .seed_s0(seed_s0), .seed_s1(seed_s1), .seed_s2(seed_s2),
    .out_valid(d0_out_valid), .out_ready(out_ready), .out_data(d0_out_data),
    .busy(d0_busy)
  );

  taus_urng_mc #(.NUM_CH(N1), .OUT_W(W1), .WARMUP(WU1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .seed_valid(seed_valid), .seed_ready(d1_seed_ready), .seed_ch(seed_ch),
    .seed_s0(seed_s0), .seed_s1(seed_s1), .seed_s2(seed_s2),
    .out_valid(d1_out_valid), .out_ready(out_ready), .out_data(d1_out_data),
    .busy(d1_busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Golden taus88, written as in the reference C generator.
  task automatic model_step(input int n);
    logic [31:0] b;
    for (int k = 0; k < n; k++) begin
      b = ((ms[k][0] << 13) ^ ms[k][0]) >> 19;
      ms[k][0] = ((ms[k][0] & 32'hFFFFFFFE) << 12) ^ b;
      b = ((ms[k][1] << 2) ^ ms[k][1]) >> 25;
      ms[k][1] = ((ms[k][1] & 32'hFFFFFFF8) << 4) ^ b;
      b = ((ms[k][2] << 3) ^ ms[k][2]) >> 11;
      ms[k][2] = ((ms[k][2] & 32'hFFFFFFF0) << 17) ^ b;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      ms[k][0] = taus_urng_pkg::DEF_S0 + 32'(k);
      ms[k][1] = taus_urng_pkg::DEF_S1 + 32'(k);
      ms[k][2] = taus_urng_pkg::DEF_S2 + 32'(k);
    end
  endtask

  function automatic logic [127:0] exp_data(input int n, input int w);
    logic [127:0] r = '0;
    logic [31:0] word;
    for (int k = 0; k < n; k++) begin
      word = ms[k][0] ^ ms[k][1] ^ ms[k][2];
      if (w == 32) r[k*32 +: 32] = word;
      else         r[k*16 +: 16] = word[31:16];
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the capturing edge.
  task automatic seed_write(input int ch, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input logic with_start);
    seed_valid = 1'b1; seed_ch = 2'(ch);
    seed_s0 = a; seed_s1 = b; seed_s2 = c; start = with_start;
    if (ch < active_n) begin
      ms[ch][0] = (a < 2)  ? (a | 32'd2)  : a;
      ms[ch][1] = (b < 8)  ? (b | 32'd8)  : b;
      ms[ch][2] = (c < 16) ? (c | 32'd16) : c;
    end
    @(negedge clk);
    seed_valid = 1'b0; start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int draws;
    logic rdy;
    rst = 1'b0; start = 1'b0; stop = 1'b0; seed_valid = 1'b0; out_ready = 1'b0;
    seed_ch = '0; seed_s0 = '0; seed_s1 = '0; seed_s2 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_seed_ready", d0_seed_ready, 1'b1);
    check("rst_out_valid", d0_out_valid, 1'b0);
    check("rst_busy", d0_busy, 1'b0);
    check("rst_data0", d0_out_data, exp_data(N0, W0));
    check("rst_data1", d1_out_data, exp_data(N1, W1));
    rst = 1'b1;
    @(negedge clk);

    // Seeds, including an all-zero seed and an out-of-range channel.
    seed_write(0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b0);
    seed_write(1, 32'h0, 32'h0, 32'h0, 1'b0);
    seed_write(3, $urandom, $urandom, $urandom, 1'b0);
    check("seed_oob_ignored", d0_out_data, exp_data(N0, W0));
    check("idle_not_valid", d0_out_valid, 1'b0);
    seed_write(2, $urandom, $urandom, $urandom, 1'b1);
    check("w0_valid_after_start", d0_out_valid, 1'b1);
    check("w0_busy", d0_busy, 1'b1);
    check("w0_seed_ready_low", d0_seed_ready, 1'b0);
    check("lane0_seed_word", d0_out_data[31:0], 32'h87878787);
    check("lane1_sanitised", d0_out_data[63:32], 32'h0000001A);
    check("seed_start_same_edge", d0_out_data, exp_data(N0, W0));

    draws = 0;
    while (draws < 1000) begin
      check("draw_data", d0_out_data, exp_data(N0, W0));
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      @(negedge clk);
      if (rdy) begin model_step(N0); draws++; end
    end
    check("draw_final", d0_out_data, exp_data(N0, W0));

    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", d0_out_data, exp_data(N0, W0));
      check("stall_valid", d0_out_valid, 1'b1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_step(N0);
      check("ready_one_step", d0_out_data, exp_data(N0, W0));
    end

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0; out_ready = 1'b0;
    check("stop_run_valid", d0_out_valid, 1'b0);
    check("stop_run_busy", d0_busy, 1'b0);
    check("stop_run_seed_ready", d0_seed_ready, 1'b1);
    check("stop_run_no_step", d0_out_data, exp_data(N0, W0));

    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle_busy", d0_busy, 1'b0);
    check("start_stop_idle_ready", d0_seed_ready, 1'b1);
    @(negedge clk);
    check("start_stop_idle_valid", d0_out_valid, 1'b0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_valid", d0_out_valid, 1'b1);
    check("restart_data", d0_out_data, exp_data(N0, W0));

    // Asynchronous reset in the middle of a RUN cycle.
    out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_valid", d0_out_valid, 1'b0);
    check("async_rst_seed_ready", d0_seed_ready, 1'b1);
    check("async_rst_busy", d0_busy, 1'b0);
    check("async_rst_data0", d0_out_data, exp_data(N0, W0));
    check("async_rst_data1", d1_out_data, exp_data(N1, W1));
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // WARMUP=16 instance with 16-bit lanes.
    active_n = N1;
    seed_write(0, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 1'b0);
    seed_write(3, $urandom, $urandom, $urandom, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("warm_busy", d1_busy, 1'b1);
    check("warm_not_valid", d1_out_valid, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      model_step(N1);
      check("warm_valid_timing", d1_out_valid, (i == 16));
    end
    check("warm_17th_word", d1_out_data, exp_data(N1, W1));

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      model_step(N1);
      check("w16_draw", d1_out_data, exp_data(N1, W1));
    end
    out_ready = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    // Stop with the warm counter at 7, then a full warm-up from kept state.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      model_step(N1);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_warm_busy", d1_busy, 1'b0);
    check("stop_warm_valid", d1_out_valid, 1'b0);
    check("stop_warm_state_kept", d1_out_data, exp_data(N1, W1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      model_step(N1);
      check("rewarm_valid_timing", d1_out_valid, (i == 16));
    end
    check("rewarm_word", d1_out_data, exp_data(N1, W1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/taus_urng_mc.md
Name: taus_urng_mc

Overview:
Multi-channel, parametrised successor of the team's three-component Tausworthe (taus88) uniform RNG. NUM_CH independent generators, each with runtime seed loading, sanitised seeds, a configurable warm-up discard period and a valid/ready output handshake. Feeds parallel AWGN/noise generators in the LDPC min-sum test datapath. Delivers one NUM_CH-wide word per accepted transfer.

Parameters:
NUM_CH, 4, number of independent generator channels (1..16)
OUT_W, 32, bits emitted per channel (1..32); the top OUT_W bits of each channel's 32-bit word
WARMUP, 16, steps discarded after start before output is valid (0..65535)
CH_W, $clog2(NUM_CH) min 1, width of seed_ch

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
start  in  1  pulse: IDLE -> WARM
stop  in  1  pulse: any state -> IDLE; generator state is kept
seed_valid  in  1  seed write request
seed_ready  out  1  high only in IDLE
seed_ch  in  CH_W  channel index of the seed write
seed_s0  in  32  component-0 seed
seed_s1  in  32  component-1 seed
seed_s2  in  32  component-2 seed
out_valid  out  1  output word valid (RUN only)
out_ready  in  1  consumer accepts the word
out_data  out  NUM_CH*OUT_W  lane k = out_data[k*OUT_W +: OUT_W]
busy  out  1  high in WARM or RUN

Behaviour:
- Reset (rst low, async): FSM = IDLE, warm counter = 0. Channel k state = DEF_S0+k, DEF_S1+k, DEF_S2+k (package constants, each component >= its minimum). Outputs: seed_ready=1, out_valid=0, busy=0, out_data = reset-state words.
- Step function per channel, all 32-bit with truncation:
  - s0' = ((s0 & FFFFFFFE)<<12) ^ (((s0<<13)^s0)>>19)
  - s1' = ((s1 & FFFFFFF8)<<4) ^ (((s1<<2)^s1)>>25)
  - s2' = ((s2 & FFFFFFF0)<<17) ^ (((s2<<3)^s2)>>11)
- Channel word = s0^s1^s2 of the current registered state. Combinational from state registers; no output register.
- Seed write: accepted when seed_valid & seed_ready. Loads channel seed_ch at the clock edge, with sanitising:
  - s0 < 2: s0 |= 2
  - s1 < 8: s1 |= 8
  - s2 < 16: s2 |= 16
  - seed_ch >= NUM_CH: write ignored.
- FSM:
  - IDLE: no stepping. start -> WARM, counter = WARMUP; if WARMUP = 0, start -> RUN directly.
  - WARM: all channels step every cycle and the counter decrements. Counter 1 -> RUN on that edge. out_valid = 0.
  - RUN: out_valid = 1. All channels step together on out_valid & out_ready; without ready the state and data hold stable.
  - stop in WARM/RUN -> IDLE next edge, no step that cycle, counter cleared.
- Simultaneous events:
  - start & stop: stop wins.
  - seed write & start in IDLE: seed is loaded and the FSM leaves IDLE on the same edge. The first WARM step uses the new seed.
  - start in WARM/RUN: ignored.
- Output word after WARMUP steps is the (WARMUP+1)-th word of the sequence, counting the seed word as the 1st.
- Lanes are updated in lockstep; no lane may step independently.
- Reset mid-operation: immediate return to reset values. Loaded seeds are lost.

Decomposition:
- Package taus_urng_pkg:
  - DEF_S0/DEF_S1/DEF_S2 constants
  - mask and shift constants
  - minimum-seed constants
  - FSM state enum (IDLE, WARM, RUN)
  - pure function taus_step(s0, s1, s2) returning next state
  - function taus_sanitise
- Sub-module taus_lane: one channel's three registers, seed load port, step enable, 32-bit word output. Instantiated NUM_CH times by a generate loop; the top holds the FSM and counter.

Test Plan:
- WARMUP=0, OUT_W=32, seed ch0 = 12345678/9ABCDEF0/0F0F0F0F, start -> next cycle out_valid=1, lane0 = 0x87878787. Subsequent accepted words match the C taus88 golden model for 1000 draws.
- Seed ch1 = 0/0/0, WARMUP=0, start -> lane1 = 0x0000001A (2^8^16).
- WARMUP=16, start -> out_valid exactly 16 cycles after start. First word equals the golden model's 17th word.
- RUN with out_ready low for 5 cycles -> out_data stable. Raise ready -> exactly one step per high-ready cycle.
- stop during WARM at count 7, then start -> full WARMUP restarts from the preserved state. Simultaneous start+stop in IDLE -> stays IDLE.
- rst low mid-RUN -> out_valid=0, seed_ready=1 asynchronously. Lane k word = (DEF_S0+k)^(DEF_S1+k)^(DEF_S2+k). seed_ch=NUM_CH write -> no lane changes.
